// File: rtl/instruction_fetch.sv
// IF stage of the five-stage MIPS pipeline: PC, instruction-memory address and the IF/ID register.
// Optional FETCH_STATS_EN adds fetch_count/stall_count outputs.
module instruction_fetch #(
  parameter int          INSTR_MEM_SIZE = 64,
  parameter int          ADDR_BITS      = 6,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          pc,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc_plus_4,
  output logic                 if_id_valid,
  output logic                 halted,
  output logic [1:0]           fsm_state
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          stall_count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] PC_LIMIT = 32'(INSTR_MEM_SIZE) << 2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_plus_4;
  logic        pc_bad;
  logic        load_fetch;
  logic        count_stall;

  assign pc_plus_4 = pc_q + 32'd4;
  assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
  assign imem_addr = pc_q[ADDR_BITS+1:2];

  // Priority in RUN: stall freezes everything, then a bad PC halts, then redirect, then fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pp4_d       = pp4_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    load_fetch  = 1'b0;
    count_stall = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          count_stall = 1'b1;
        end else if (pc_bad) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          instr_d  = 32'h0;
          pp4_d    = 32'h0;
          valid_d  = 1'b0;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = 32'h0;
          pp4_d   = 32'h0;
          valid_d = 1'b0;
        end else begin
          pc_d       = pc_plus_4;
          instr_d    = imem_data;
          pp4_d      = pc_plus_4;
          valid_d    = 1'b1;
          load_fetch = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pp4_q    <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pp4_q    <= pp4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc              = pc_q;
  assign if_id_instr     = instr_q;
  assign if_id_pc_plus_4 = pp4_q;
  assign if_id_valid     = valid_q;
  assign halted          = halted_q;
  assign fsm_state       = state_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign fetch_cnt_d = load_fetch  ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
  assign stall_cnt_d = count_stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = load_fetch ^ count_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural fetch model.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus_4;
  logic        if_id_valid;
  logic        halted;
  logic [1:0]  fsm_state;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  instruction_fetch #(.INSTR_MEM_SIZE(64), .ADDR_BITS(6), .RESET_PC(32'h0)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc              (pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus_4 (if_id_pc_plus_4),
    .if_id_valid     (if_id_valid),
    .halted          (halted),
    .fsm_state       (fsm_state)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
`endif
  );

  // clock / memory
  always #5 clock = ~clock;
  assign imem_data = 32'h2000_0000 | {26'h0, imem_addr};

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pp4, input logic e_valid, input logic e_halted);
    logic [31:0] e_addr;
    e_addr = (e_pc >> 2) & 32'h3f;
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, {26'h0, imem_addr}, e_addr);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".pc_plus_4"}, if_id_pc_plus_4, e_pp4);
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
    check({tag, ".halted"}, {31'h0, halted}, {31'h0, e_halted});
  endtask

  // behavioural model
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_halted, m_first_edge;
  int unsigned m_fetches, m_stalls;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;
    m_first_edge = 1; m_fetches = 0; m_stalls = 0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
    if (m_first_edge) begin
      m_first_edge = 0;
    end else if (!m_halted) begin
      if (s) begin
        m_stalls++;
      end else if ((m_pc % 4) != 0 || m_pc >= 64 * 4) begin
        m_halted = 1; m_instr = 0; m_pp4 = 0; m_valid = 0;
      end else if (b) begin
        m_pc = t; m_instr = 0; m_pp4 = 0; m_valid = 0;
      end else begin
        m_instr = 32'h2000_0000 + m_pc / 4;
        m_pp4   = m_pc + 4;
        m_valid = 1;
        m_pc    = m_pc + 4;
        m_fetches++;
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    stall = 0; branch_taken = 0; branch_target = 0;
    reset = 1;
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset.state", {30'h0, fsm_state}, 32'h0);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic step(input logic s, input logic b, input logic [31:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clock);
    #1;
    model_edge(s, b, t);
  endtask

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic [31:0] p, logic [31:0] i,
                              logic [31:0] p4, logic v, logic h);
    vec_t r;
    r.s = s; r.b = b; r.t = t; r.e_pc = p; r.e_instr = i; r.e_pp4 = p4; r.e_valid = v; r.e_halted = h;
    return r;
  endfunction

  initial begin
    vecs[0]  = mk(0, 0, 0,   0,   32'h0,         0,   0, 0);
    vecs[1]  = mk(0, 0, 0,   4,   32'h2000_0000, 4,   1, 0);
    vecs[2]  = mk(0, 0, 0,   8,   32'h2000_0001, 8,   1, 0);
    vecs[3]  = mk(0, 0, 0,   12,  32'h2000_0002, 12,  1, 0);
    vecs[4]  = mk(1, 0, 0,   12,  32'h2000_0002, 12,  1, 0);
    vecs[5]  = mk(1, 0, 0,   12,  32'h2000_0002, 12,  1, 0);
    vecs[6]  = mk(1, 0, 0,   12,  32'h2000_0002, 12,  1, 0);
    vecs[7]  = mk(0, 0, 0,   16,  32'h2000_0003, 16,  1, 0);
    vecs[8]  = mk(0, 1, 40,  40,  32'h0,         0,   0, 0);
    vecs[9]  = mk(0, 0, 0,   44,  32'h2000_000A, 44,  1, 0);
    vecs[10] = mk(1, 1, 100, 44,  32'h2000_000A, 44,  1, 0);
    vecs[11] = mk(0, 1, 100, 100, 32'h0,         0,   0, 0);
    vecs[12] = mk(0, 0, 0,   104, 32'h2000_0019, 104, 1, 0);
    vecs[13] = mk(0, 1, 256, 256, 32'h0,         0,   0, 0);
    vecs[14] = mk(0, 0, 0,   256, 32'h0,         0,   0, 1);
    vecs[15] = mk(0, 1, 0,   256, 32'h0,         0,   0, 1);
    vecs[16] = mk(1, 0, 0,   256, 32'h0,         0,   0, 1);

    // directed table
    @(posedge clock);
    #1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].s, vecs[i].b, vecs[i].t);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
                vecs[i].e_valid, vecs[i].e_halted);
`ifdef FETCH_STATS_EN
      if (i == 6) check("vec6.stall_count", stall_count, 32'd3);
`endif
    end
`ifdef FETCH_STATS_EN
    check("table.stall_count", stall_count, 32'd4);
    check("table.fetch_count", fetch_count, 32'd6);
`endif

    // misaligned branch target halts one edge after being loaded
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 6);
    check_all("misalign.load", 32'd6, 32'h0, 32'h0, 1'b0, 1'b0);
    step(0, 0, 0);
    check_all("misalign.halt", 32'd6, 32'h0, 32'h0, 1'b0, 1'b1);

    // stall holds off the halt on a bad pc; last legal word is fetched first
    do_reset();
    step(0, 0, 0);
    step(0, 1, 252);
    step(0, 0, 0);
    check_all("last.word", 32'd256, 32'h2000_003F, 32'd256, 1'b1, 1'b0);
    step(1, 0, 0);
    step(1, 1, 8);
    check_all("bad.stalled", 32'd256, 32'h2000_003F, 32'd256, 1'b1, 1'b0);
    step(0, 0, 0);
    check_all("bad.halt", 32'd256, 32'h0, 32'h0, 1'b0, 1'b1);

    // asynchronous reset in the middle of a cycle
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    #2;
    do_reset();
    step(0, 0, 0);
    check_all("post_reset.boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic        rs, rb;
      logic [31:0] rt;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end
      rs = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 6) == 0);
      rt = 32'($urandom_range(0, 66)) * 4;
      if ($urandom_range(0, 9) == 0) rt = rt + 32'($urandom_range(1, 3));
      step(rs, rb, rt);
      check_all("rand", m_pc, m_instr, m_pp4, m_valid, m_halted);
`ifdef FETCH_STATS_EN
      check("rand.fetch_count", fetch_count, m_fetches);
      check("rand.stall_count", stall_count, m_stalls);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
